// File: rtl/slc3_mem_responder.sv
// SRAM-style responder for the SLC-3 memory bus: fixed-latency OE/WE accesses with a
// one-cycle Ready pulse, a sticky range-error flag and a program-load write port.
module slc3_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       Data_to_SRAM,
    input  logic              OE,
    input  logic              WE,
    output logic [15:0]       Data_from_SRAM,
    output logic              Ready,
    output logic              Addr_err,
    input  logic              Init_Mode,
    input  logic              Init_WE,
    input  logic [ADDR_W-1:0] Init_ADDR,
    input  logic [15:0]       Init_Data
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic        write_reg, write_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        ready_reg, ready_next;
    logic        err_reg, err_next;

    logic [15:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;
    logic              in_range;

    assign in_range = ((addr_reg >> ADDR_W) == 16'd0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        write_next = write_reg;
        rdata_next = rdata_reg;
        ready_next = 1'b0;
        err_next   = err_reg;
        mem_we     = 1'b0;
        mem_waddr  = addr_reg[ADDR_W-1:0];
        mem_wdata  = wdata_reg;

        if (Init_Mode) begin
            // Program load owns the array; any CPU access in flight is abandoned.
            state_next = IDLE;
            mem_we     = Init_WE;
            mem_waddr  = Init_ADDR;
            mem_wdata  = Init_Data;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (OE || WE) begin
                        addr_next  = ADDR;
                        wdata_next = Data_to_SRAM;
                        write_next = WE;
                        cnt_next   = 4'(LATENCY - 1);
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        ready_next = 1'b1;
                        state_next = HOLD;
                        if (!in_range) begin
                            err_next = 1'b1;
                            if (!write_reg) rdata_next = 16'h0000;
                        end else if (write_reg) begin
                            mem_we = 1'b1;
                        end else begin
                            rdata_next = mem[addr_reg[ADDR_W-1:0]];
                        end
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
                HOLD: begin
                    // The CPU keeps OE asserted across several control states.
                    if (!(OE || WE)) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 16'd0;
            wdata_reg <= 16'd0;
            write_reg <= 1'b0;
            rdata_reg <= 16'd0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            write_reg <= write_next;
            rdata_reg <= rdata_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
        end
    end

    // Array contents survive reset; an aborted access never reaches the commit point.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign Data_from_SRAM = rdata_reg;
    assign Ready          = ready_reg;
    assign Addr_err       = err_reg;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder with default parameters (ADDR_W=10, LATENCY=2).
module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        OE;
    logic        WE;
    logic [15:0] Data_from_SRAM;
    logic        Ready;
    logic        Addr_err;
    logic        Init_Mode;
    logic        Init_WE;
    logic [9:0]  Init_ADDR;
    logic [15:0] Init_Data;

    int checks   = 0;
    int failures = 0;
    int rdy_cnt;
    int rdy_first;

    slc3_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .OE             (OE),
        .WE             (WE),
        .Data_from_SRAM (Data_from_SRAM),
        .Ready          (Ready),
        .Addr_err       (Addr_err),
        .Init_Mode      (Init_Mode),
        .Init_WE        (Init_WE),
        .Init_ADDR      (Init_ADDR),
        .Init_Data      (Init_Data)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a request before edge E0; tick i samples just after edge E0+i-1.
    // Ready for LATENCY=2 is therefore expected on tick 3.
    task automatic run_req(input logic oe, input logic we, input logic [15:0] addr,
                           input logic [15:0] data, input int n_hold);
        OE = oe; WE = we; ADDR = addr; Data_to_SRAM = data;
        rdy_cnt = 0; rdy_first = 0;
        for (int i = 1; i <= n_hold + 3; i++) begin
            tick();
            if (Ready === 1'b1) begin
                rdy_cnt++;
                if (rdy_first == 0) rdy_first = i;
            end
            if (i == n_hold) begin
                OE = 1'b0;
                WE = 1'b0;
            end
        end
        $display("req oe=%0b we=%0b addr=%04h data=%04h -> ready_cnt=%0d first=%0d rdata=%04h err=%0b",
                 oe, we, addr, data, rdy_cnt, rdy_first, Data_from_SRAM, Addr_err);
    endtask

    initial begin
        Reset = 1'b1; ADDR = 16'd0; Data_to_SRAM = 16'd0; OE = 1'b0; WE = 1'b0;
        Init_Mode = 1'b0; Init_WE = 1'b0; Init_ADDR = 10'd0; Init_Data = 16'd0;
        #2 Reset = 1'b0;
        tick(); tick();
        check("reset_rdata", 32'(Data_from_SRAM), 32'h0);
        check("reset_ready", 32'(Ready), 32'h0);
        check("reset_err", 32'(Addr_err), 32'h0);
        Reset = 1'b1;
        tick();

        // Program load
        Init_Mode = 1'b1; Init_WE = 1'b1;
        Init_ADDR = 10'h005; Init_Data = 16'h1234; tick();
        Init_ADDR = 10'h030; Init_Data = 16'h1111; tick();
        Init_ADDR = 10'h000; Init_Data = 16'hCAFE; tick();
        Init_WE = 1'b0; Init_Mode = 1'b0;
        $display("init load done");

        run_req(1'b1, 1'b0, 16'h0005, 16'h0000, 3);
        check("rd5_ready_cnt", 32'(rdy_cnt), 32'd1);
        check("rd5_ready_time", 32'(rdy_first), 32'd3);
        check("rd5_data_held", 32'(Data_from_SRAM), 32'h1234);

        run_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 3);
        check("wr10_ready_cnt", 32'(rdy_cnt), 32'd1);
        check("wr10_ready_time", 32'(rdy_first), 32'd3);
        check("wr10_rdata_unchanged", 32'(Data_from_SRAM), 32'h1234);

        run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 3);
        check("rd10_ready_cnt", 32'(rdy_cnt), 32'd1);
        check("rd10_data", 32'(Data_from_SRAM), 32'hBEEF);

        run_req(1'b1, 1'b0, 16'h0005, 16'h0000, 10);
        check("held_oe_ready_cnt", 32'(rdy_cnt), 32'd1);
        check("held_oe_data", 32'(Data_from_SRAM), 32'h1234);
        check("err_before_oor", 32'(Addr_err), 32'h0);

        run_req(1'b1, 1'b0, 16'h0400, 16'h0000, 3);
        check("oor_rd_ready_cnt", 32'(rdy_cnt), 32'd1);
        check("oor_rd_data", 32'(Data_from_SRAM), 32'h0000);
        check("oor_rd_err", 32'(Addr_err), 32'h1);

        run_req(1'b0, 1'b1, 16'h0400, 16'h5555, 3);
        check("oor_wr_ready_cnt", 32'(rdy_cnt), 32'd1);
        run_req(1'b1, 1'b0, 16'h0000, 16'h0000, 3);
        check("mem0_unchanged", 32'(Data_from_SRAM), 32'hCAFE);
        check("err_sticky", 32'(Addr_err), 32'h1);

        run_req(1'b1, 1'b1, 16'h0020, 16'h00AA, 3);
        check("oewe_ready_cnt", 32'(rdy_cnt), 32'd1);
        check("oewe_rdata_unchanged", 32'(Data_from_SRAM), 32'hCAFE);
        run_req(1'b1, 1'b0, 16'h0020, 16'h0000, 3);
        check("oewe_written", 32'(Data_from_SRAM), 32'h00AA);

        // Requests are ignored during Init_Mode and sampled once it falls.
        Init_Mode = 1'b1; OE = 1'b1; ADDR = 16'h0010;
        tick();
        check("init_block_ready_a", 32'(Ready), 32'h0);
        tick();
        check("init_block_ready_b", 32'(Ready), 32'h0);
        Init_Mode = 1'b0;
        run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 3);
        check("init_fall_ready_time", 32'(rdy_first), 32'd3);
        check("init_fall_data", 32'(Data_from_SRAM), 32'hBEEF);

        // Reset one cycle into WAIT must abort the write.
        OE = 1'b0; WE = 1'b1; ADDR = 16'h0030; Data_to_SRAM = 16'h7777;
        tick();
        Reset = 1'b0;
        #1;
        check("midwait_rst_rdata", 32'(Data_from_SRAM), 32'h0);
        check("midwait_rst_ready", 32'(Ready), 32'h0);
        check("midwait_rst_err", 32'(Addr_err), 32'h0);
        tick(); tick();
        WE = 1'b0;
        Reset = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Ready === 1'b1) rdy_cnt++;
        end
        $display("reset mid-wait: ready after release=%0d", rdy_cnt);
        check("midwait_no_ready", 32'(rdy_cnt), 32'd0);
        run_req(1'b1, 1'b0, 16'h0030, 16'h0000, 3);
        check("midwait_mem_kept", 32'(Data_from_SRAM), 32'h1111);
        check("midwait_err_clear", 32'(Addr_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slc3_mem_responder.md
Name: slc3_mem_responder

Overview:
- Memory-side responder for the SLC-3 core's memory interface. It answers the CPU's OE/WE requests on ADDR / Data_to_SRAM / Data_from_SRAM.
- It models on-chip SRAM with a configurable access latency and has a Ready pulse.
- It includes a program-load port so test programs can be written before the CPU runs.
- It sits between the CPU's memory I/O path and the board-level top, replacing the ideal zero-wait memory.

Parameters:
ADDR_W, 10, word-address bits implemented; depth = 2**ADDR_W 16-bit words.
LATENCY, 2, wait cycles from request sample to data/Ready; legal range 1..15.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  asynchronous, active-low reset.
ADDR  in  16  word address from CPU MAR.
Data_to_SRAM  in  16  write data from CPU.
OE  in  1  read request, active-high, level held by CPU.
WE  in  1  write request, active-high, level held by CPU.
Data_from_SRAM  out  16  read data, registered.
Ready  out  1  one-cycle completion pulse.
Addr_err  out  1  sticky out-of-range access flag.
Init_Mode  in  1  program-load mode; CPU requests ignored while high.
Init_WE  in  1  load strobe, valid only when Init_Mode=1.
Init_ADDR  in  ADDR_W  load address.
Init_Data  in  16  load data.

Behaviour:
- Reset (Reset=0, async):
  - State goes to IDLE.
  - Data_from_SRAM=0, Ready=0, Addr_err=0, wait counter=0.
  - Memory array is NOT cleared.
  - Reset mid-access aborts it: no write is committed and no Ready is produced.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - If Init_Mode=0 and (OE|WE)=1 at a rising edge E0:
    - Capture ADDR, Data_to_SRAM and op. WE has priority; OE&WE together is a write.
    - Load counter with LATENCY-1 and go to WAIT.
  - Inputs changing after E0 are ignored for this access.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0 (E0+LATENCY), the access is performed and the state goes to HOLD.
  - Read, in range: Data_from_SRAM <= mem[captured addr].
  - Read, out of range (ADDR[15:ADDR_W]!=0): Data_from_SRAM <= 16'h0000, Addr_err <= 1.
  - Write, in range: mem[captured addr] <= captured data. Data_from_SRAM is unchanged.
  - Write, out of range: dropped, Addr_err <= 1.
  - Ready <= 1 on the same edge.
- Ready timing: high exactly one cycle (cleared at E0+LATENCY+1), regardless of OE/WE.
- Data_from_SRAM holds its value until the next completed read or reset.
- HOLD:
  - Stays while OE|WE sampled high. The CPU holds OE across several ISDU states; this prevents re-triggering.
  - Goes to IDLE at the first edge with OE=0 and WE=0.
  - Minimum spacing between accesses is therefore LATENCY+2 edges.
- Init_Mode=1:
  - At the next edge, the state is forced to IDLE and any in-flight access is aborted (no write, no Ready).
  - Each edge with Init_WE=1 writes mem[Init_ADDR] <= Init_Data.
  - Data_from_SRAM and Addr_err are unaffected.
- Init_Mode falling with OE already high: the request is sampled at the first edge with Init_Mode=0.
- Addr_err clears only on reset.
- Memory read-during-write does not occur, since accesses are serialized.

Test Plan:
- Load and read, LATENCY=2:
  - Stimulus: Init writes mem[0x005]=0x1234; Init_Mode=0; OE=1, ADDR=0x0005 sampled at E0.
  - Required: Ready=1 only in the cycle after E0+2, Data_from_SRAM=0x1234 and held after OE drops.
- Write then read:
  - Stimulus: WE=1, ADDR=0x0010, data 0xBEEF; drop WE after Ready; then OE at 0x0010.
  - Required: read returns 0xBEEF; exactly one Ready per request.
- Held OE (no re-trigger):
  - Stimulus: OE held high 10 cycles.
  - Required: exactly one Ready; state HOLD until OE=0.
- Out of range, ADDR_W=10:
  - Stimulus: read at 0x0400.
  - Required: Data_from_SRAM=0x0000, Addr_err=1 and still 1 after later valid accesses.
  - Stimulus: write 0x5555 at 0x0400.
  - Required: mem[0x000] unchanged.
- OE&WE simultaneous:
  - Stimulus: ADDR=0x0020, data 0x00AA.
  - Required: treated as a write; mem[0x020]=0x00AA; Data_from_SRAM unchanged.
- Reset mid-WAIT:
  - Stimulus: write 0x7777 to 0x0030 (prior 0x1111); assert Reset=0 one cycle after E0.
  - Required: outputs zero immediately (async); mem[0x030] stays 0x1111; no Ready after release.
